// File: rtl/regm_pkg.sv
// Shared types and sizes for the integer register file and its hazard scoreboard.
package ecap5_dproc_pkg;

    localparam int NB_REGS = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regm_if.sv
// Decode read ports, reservation handshake and write-back bus of the register file.
interface regm_if;
    import ecap5_dproc_pkg::*;

    reg_addr_t rs1_addr_i;
    reg_addr_t rs2_addr_i;
    reg_data_t rs1_data_o;
    reg_data_t rs2_data_o;
    logic      rs1_pending_o;
    logic      rs2_pending_o;
    logic      reserve_valid_i;
    reg_addr_t reserve_addr_i;
    logic      reserve_ready_o;
    logic      wb_valid_i;
    logic      wb_write_i;
    reg_addr_t wb_addr_i;
    reg_data_t wb_data_i;

    modport master (
        output rs1_addr_i, rs2_addr_i, reserve_valid_i, reserve_addr_i,
               wb_valid_i, wb_write_i, wb_addr_i, wb_data_i,
        input  rs1_data_o, rs2_data_o, rs1_pending_o, rs2_pending_o, reserve_ready_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, reserve_valid_i, reserve_addr_i,
               wb_valid_i, wb_write_i, wb_addr_i, wb_data_i,
        output rs1_data_o, rs2_data_o, rs1_pending_o, rs2_pending_o, reserve_ready_o
    );

endinterface

// File: rtl/regm_scoreboard.sv
// Per-register in-flight write counters with saturating reserve and clamped release.
// REGM_BYPASS_EN makes pending reflect a same-cycle release.
module regm_scoreboard
    import ecap5_dproc_pkg::*;
#(
    parameter int PENDING_W = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      i_reserve_valid,
    input  reg_addr_t i_reserve_addr,
    output logic      o_reserve_ready,
    input  logic      i_release_valid,
    input  reg_addr_t i_release_addr,
    input  reg_addr_t i_rs1_addr,
    input  reg_addr_t i_rs2_addr,
    output logic      o_rs1_pending,
    output logic      o_rs2_pending
);

    localparam logic [PENDING_W-1:0] CNT_MAX = '1;
    localparam logic [PENDING_W-1:0] CNT_ONE = PENDING_W'(1);

    logic [PENDING_W-1:0] r_count [NB_REGS];
    logic [NB_REGS-1:0]   w_inc;
    logic [NB_REGS-1:0]   w_dec;
    logic                 w_reserve_fire;

    function automatic logic isPending(reg_addr_t a, logic [PENDING_W-1:0] cnt,
                                       logic rel_valid, reg_addr_t rel_addr);
        logic pend;
        pend = (a != '0) && (cnt != '0);
`ifdef REGM_BYPASS_EN
        if (rel_valid && (rel_addr == a) && (cnt == CNT_ONE)) begin
            pend = 1'b0;
        end
`else
        if (rel_valid && (rel_addr == a) && 1'b0) begin
            pend = 1'b0;
        end
`endif
        return pend;
    endfunction

    // A release of the same register frees the slot the reservation needs.
    always_comb begin
        o_reserve_ready = (r_count[i_reserve_addr] != CNT_MAX) ||
                          (i_release_valid && (i_release_addr == i_reserve_addr));
        w_reserve_fire  = i_reserve_valid && o_reserve_ready && (i_reserve_addr != '0);
        o_rs1_pending   = isPending(i_rs1_addr, r_count[i_rs1_addr], i_release_valid, i_release_addr);
        o_rs2_pending   = isPending(i_rs2_addr, r_count[i_rs2_addr], i_release_valid, i_release_addr);
        w_inc           = '0;
        w_dec           = '0;
        for (int i = 1; i < NB_REGS; i++) begin
            w_inc[i] = w_reserve_fire && (i_reserve_addr == reg_addr_t'(i));
            w_dec[i] = i_release_valid && (i_release_addr == reg_addr_t'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_REGS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_REGS; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_count[i] <= r_count[i] + CNT_ONE;
                end else if (w_dec[i] && !w_inc[i] && (r_count[i] != '0)) begin
                    r_count[i] <= r_count[i] - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: rtl/regm.sv
// Integer register file x0..x31 with two registered read ports and a RAW hazard scoreboard.
// REGM_BYPASS_EN forwards a same-edge write-back to the read ports.
module regm
    import ecap5_dproc_pkg::*;
#(
    parameter int PENDING_W = 2
) (
    input logic   clk_i,
    input logic   rst_ni,
    regm_if.slave bus
);

    reg_data_t r_regs [NB_REGS];
    reg_data_t r_rs1_data;
    reg_data_t r_rs2_data;
    reg_data_t w_rs1_next;
    reg_data_t w_rs2_next;
    logic      w_commit;

    assign w_commit = bus.wb_valid_i && bus.wb_write_i && (bus.wb_addr_i != '0);

    always_comb begin
        w_rs1_next = r_regs[bus.rs1_addr_i];
        w_rs2_next = r_regs[bus.rs2_addr_i];
`ifdef REGM_BYPASS_EN
        if (w_commit && (bus.wb_addr_i == bus.rs1_addr_i)) begin
            w_rs1_next = bus.wb_data_i;
        end
        if (w_commit && (bus.wb_addr_i == bus.rs2_addr_i)) begin
            w_rs2_next = bus.wb_data_i;
        end
`endif
        if (bus.rs1_addr_i == '0) begin
            w_rs1_next = '0;
        end
        if (bus.rs2_addr_i == '0) begin
            w_rs2_next = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NB_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            if (w_commit) begin
                r_regs[bus.wb_addr_i] <= bus.wb_data_i;
            end
            r_rs1_data <= w_rs1_next;
            r_rs2_data <= w_rs2_next;
        end
    end

    assign bus.rs1_data_o = r_rs1_data;
    assign bus.rs2_data_o = r_rs2_data;

    regm_scoreboard #(
        .PENDING_W(PENDING_W)
    ) u_scoreboard (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .i_reserve_valid (bus.reserve_valid_i),
        .i_reserve_addr  (bus.reserve_addr_i),
        .o_reserve_ready (bus.reserve_ready_o),
        .i_release_valid (w_commit),
        .i_release_addr  (bus.wb_addr_i),
        .i_rs1_addr      (bus.rs1_addr_i),
        .i_rs2_addr      (bus.rs2_addr_i),
        .o_rs1_pending   (bus.rs1_pending_o),
        .o_rs2_pending   (bus.rs2_pending_o)
    );

endmodule

// File: tb/tb_regm.sv
// Scoreboard bench for regm: expected read data queued at drive time, popped after the edge.
module tb_regm;
    import ecap5_dproc_pkg::*;

    localparam int PENDING_W = 2;
    localparam int CNT_MAX   = (1 << PENDING_W) - 1;
`ifdef REGM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    bit   checkComb = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mdlRegs [NB_REGS];
    int          mdlCnt  [NB_REGS];
    logic [31:0] expQ1 [$];
    logic [31:0] expQ2 [$];

    regm_if bus();

    regm #(.PENDING_W(PENDING_W)) dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic expPending(reg_addr_t a, logic commit, reg_addr_t wbA);
        int eff;
        eff = mdlCnt[a];
        if (BYPASS && commit && (wbA == a) && (eff != 0)) eff--;
        return (a != 0) && (eff != 0);
    endfunction

    // One clock: drive at negedge, check combinational flags, queue read data, check after posedge.
    task automatic applyStimulus(input logic rst, input reg_addr_t r1, input reg_addr_t r2,
                                 input logic resV, input reg_addr_t resA,
                                 input logic wbV, input logic wbW, input reg_addr_t wbA,
                                 input logic [31:0] wbD);
        logic commit;
        logic readyExp;
        logic inc;
        logic dec;
        logic [31:0] d1;
        logic [31:0] d2;
        @(negedge clk);
        rstN                = rst;
        bus.rs1_addr_i      = r1;
        bus.rs2_addr_i      = r2;
        bus.reserve_valid_i = resV;
        bus.reserve_addr_i  = resA;
        bus.wb_valid_i      = wbV;
        bus.wb_write_i      = wbW;
        bus.wb_addr_i       = wbA;
        bus.wb_data_i       = wbD;
        #1;
        commit   = wbV && wbW && (wbA != 0);
        readyExp = (mdlCnt[resA] != CNT_MAX) || (commit && (wbA == resA));
        if (checkComb) begin
            checkOutput("pending1", {31'd0, bus.rs1_pending_o}, {31'd0, expPending(r1, commit, wbA)});
            checkOutput("pending2", {31'd0, bus.rs2_pending_o}, {31'd0, expPending(r2, commit, wbA)});
            checkOutput("ready", {31'd0, bus.reserve_ready_o}, {31'd0, readyExp});
        end
        d1 = (r1 == 0) ? 32'd0 : ((BYPASS && commit && (wbA == r1)) ? wbD : mdlRegs[r1]);
        d2 = (r2 == 0) ? 32'd0 : ((BYPASS && commit && (wbA == r2)) ? wbD : mdlRegs[r2]);
        if (!rst) begin
            d1 = 32'd0;
            d2 = 32'd0;
        end
        expQ1.push_back(d1);
        expQ2.push_back(d2);
        if (!rst) begin
            for (int i = 0; i < NB_REGS; i++) begin
                mdlRegs[i] = 32'd0;
                mdlCnt[i]  = 0;
            end
        end else begin
            for (int i = 1; i < NB_REGS; i++) begin
                inc = resV && readyExp && (resA == i);
                dec = commit && (wbA == i);
                if (inc && !dec) mdlCnt[i]++;
                else if (dec && !inc && (mdlCnt[i] > 0)) mdlCnt[i]--;
            end
            if (commit) mdlRegs[wbA] = wbD;
        end
        @(posedge clk);
        #1;
        if (expQ1.size() == 0 || expQ2.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL queue: got empty expected entry");
        end else begin
            checkOutput("rs1_data", bus.rs1_data_o, expQ1.pop_front());
            checkOutput("rs2_data", bus.rs2_data_o, expQ2.pop_front());
        end
    endtask

    initial begin
        for (int i = 0; i < NB_REGS; i++) begin
            mdlRegs[i] = 32'd0;
            mdlCnt[i]  = 0;
        end
        bus.rs1_addr_i = '0; bus.rs2_addr_i = '0;
        bus.reserve_valid_i = 1'b0; bus.reserve_addr_i = '0;
        bus.wb_valid_i = 1'b0; bus.wb_write_i = 1'b0; bus.wb_addr_i = '0; bus.wb_data_i = '0;

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 5, 32'h5555_5555);
        checkComb = 1'b1;
        applyStimulus(1, 5, 31, 0, 5, 0, 0, 0, 0);
        checkOutput("rstReady", {31'd0, bus.reserve_ready_o}, 32'd1);
        checkOutput("rstRd1", bus.rs1_data_o, 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 1, 1, 7, 32'hDEAD_BEEF);
        applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x7read", bus.rs1_data_o, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 32'h0000_1234);
        applyStimulus(1, 0, 7, 0, 0, 0, 0, 0, 0);
        checkOutput("x0read", bus.rs1_data_o, 32'd0);

        applyStimulus(1, 0, 3, 1, 3, 0, 0, 0, 0);
        applyStimulus(1, 0, 3, 1, 3, 0, 0, 0, 0);
        applyStimulus(1, 0, 3, 0, 0, 1, 1, 3, 32'h0000_0033);
        applyStimulus(1, 0, 3, 0, 0, 1, 1, 3, 32'h0000_0034);
        applyStimulus(1, 3, 3, 0, 0, 0, 0, 0, 0);
        checkOutput("x3free", {31'd0, bus.rs2_pending_o}, 32'd0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 0);

        applyStimulus(1, 9, 0, 1, 9, 0, 0, 0, 0);
        applyStimulus(1, 9, 0, 1, 9, 0, 0, 0, 0);
        applyStimulus(1, 9, 0, 1, 9, 0, 0, 0, 0);
        applyStimulus(1, 9, 0, 1, 9, 0, 0, 0, 0);
        checkOutput("satReady", {31'd0, bus.reserve_ready_o}, 32'd0);
        applyStimulus(1, 9, 0, 1, 9, 1, 1, 9, 32'h0000_0099);
        checkOutput("satRelReady", {31'd0, bus.reserve_ready_o}, 32'd1);
        applyStimulus(1, 9, 0, 1, 9, 0, 0, 0, 0);
        checkOutput("satHeld", {31'd0, bus.reserve_ready_o}, 32'd0);

        applyStimulus(1, 4, 4, 0, 0, 1, 1, 4, 32'hA5A5_A5A5);
        checkOutput("x4same", bus.rs1_data_o, BYPASS ? 32'hA5A5_A5A5 : 32'd0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0);

        applyStimulus(1, 12, 12, 0, 0, 1, 1, 12, 32'h0C0C_0C0C);
        applyStimulus(1, 12, 12, 1, 12, 0, 0, 0, 0);
        applyStimulus(1, 12, 12, 0, 0, 1, 1, 12, 32'h0C0C_0C0D);
        applyStimulus(1, 12, 12, 0, 0, 0, 0, 0, 0);
        checkOutput("x12data", bus.rs1_data_o, 32'h0C0C_0C0D);

        applyStimulus(1, 2, 0, 1, 2, 0, 0, 0, 0);
        applyStimulus(0, 2, 0, 0, 0, 1, 1, 2, 32'h2222_2222);
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x2afterRst", {31'd0, bus.rs1_pending_o}, 32'd0);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1, reg_addr_t'($urandom_range(0, 4)), reg_addr_t'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 4)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          reg_addr_t'($urandom_range(0, 4)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
